// File: rtl/mul_imm_sequencer.sv
// Expands rd = rs * imm into MOVR/MOVI/ADD/LSLI micro-ops for the ghost-instruction path.
// One micro-op per valid/ready handshake; all outputs come straight from registers.
module mul_imm_sequencer #(
    parameter logic [3:0] SCRATCH_REG = 4'd15,
    parameter int         IMM_W       = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [3:0]                        mul_rd,
    input  logic [3:0]                        mul_rs,
    input  logic [IMM_W-1:0]                  mul_imm,
    input  logic                              flush,
    output logic                              uop_valid,
    input  logic                              uop_ready,
    output logic [1:0]                        uop_kind,
    output logic [3:0]                        uop_rd,
    output logic [3:0]                        uop_rs1,
    output logic [3:0]                        uop_rs2,
    output logic [IMM_W-1:0]                  uop_imm,
    output logic [$clog2(2*IMM_W+1)-1:0]      uop_index,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    localparam int IDX_W = $clog2(2*IMM_W+1);
    localparam int BIT_W = $clog2(IMM_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COPY,
        S_CLEAR,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        K_MOVR = 2'd0,
        K_MOVI = 2'd1,
        K_ADD  = 2'd2,
        K_LSLI = 2'd3
    } kind_t;

    state_t             state_reg, state_next;
    logic [3:0]         rd_reg, rd_next;
    logic [3:0]         rs_reg, rs_next;
    logic [IMM_W-1:0]   imm_reg, imm_next;
    logic [BIT_W-1:0]   bit_reg, bit_next;
    logic [IDX_W-1:0]   index_reg, index_next;

    logic               valid_reg, valid_next;
    kind_t              kind_reg, kind_next;
    logic [3:0]         urd_reg, urd_next;
    logic [3:0]         urs1_reg, urs1_next;
    logic [3:0]         urs2_reg, urs2_next;
    logic [IMM_W-1:0]   uimm_reg, uimm_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;

    logic               fire;
    logic [BIT_W:0]     bit_inc;
    logic [IMM_W-1:0]   imm_above;
    logic               bad_operand;

    assign fire        = valid_reg & uop_ready;
    // One extra bit so i+1 can reach IMM_W without wrapping back to bit 0.
    assign bit_inc     = {1'b0, bit_reg} + {{BIT_W{1'b0}}, 1'b1};
    assign imm_above   = imm_reg >> bit_inc;
    assign bad_operand = (mul_rd == SCRATCH_REG) || (mul_rs == SCRATCH_REG);

    // Next-state, operand latching and micro-op counter.
    always_comb begin
        state_next = state_reg;
        rd_next    = rd_reg;
        rs_next    = rs_reg;
        imm_next   = imm_reg;
        bit_next   = bit_reg;
        index_next = index_reg;
        err_next   = 1'b0;

        if (state_reg != S_IDLE && flush) begin
            // A micro-op presented alongside flush is treated as never issued.
            state_next = S_IDLE;
            index_next = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start && !flush) begin
                        if (bad_operand) begin
                            err_next = 1'b1;
                        end else begin
                            rd_next    = mul_rd;
                            rs_next    = mul_rs;
                            imm_next   = mul_imm;
                            bit_next   = '0;
                            index_next = '0;
                            state_next = (mul_imm == '0) ? S_CLEAR : S_COPY;
                        end
                    end
                end
                S_COPY: begin
                    if (fire) begin
                        index_next = index_reg + 1'b1;
                        state_next = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (fire) begin
                        index_next = index_reg + 1'b1;
                        if (imm_reg == '0)
                            state_next = S_DONE;
                        else if (imm_reg[0])
                            state_next = S_ADD;
                        else
                            state_next = S_SHIFT;
                    end
                end
                S_ADD: begin
                    if (fire) begin
                        index_next = index_reg + 1'b1;
                        state_next = (imm_above == '0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Only reached while a higher set bit remains, so bit_inc stays in range.
                    if (fire) begin
                        index_next = index_reg + 1'b1;
                        bit_next   = bit_inc[BIT_W-1:0];
                        state_next = imm_above[0] ? S_ADD : S_SHIFT;
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                    index_next = '0;
                end
                default: begin
                    state_next = S_IDLE;
                    index_next = '0;
                end
            endcase
        end
    end

    // Micro-op fields are decoded from the upcoming state so they register alongside it.
    always_comb begin
        valid_next = 1'b0;
        kind_next  = K_MOVR;
        urd_next   = '0;
        urs1_next  = '0;
        urs2_next  = '0;
        uimm_next  = '0;
        busy_next  = (state_next != S_IDLE);
        done_next  = (state_next == S_DONE);

        case (state_next)
            S_COPY: begin
                valid_next = 1'b1;
                kind_next  = K_MOVR;
                urd_next   = SCRATCH_REG;
                urs1_next  = rs_next;
            end
            S_CLEAR: begin
                valid_next = 1'b1;
                kind_next  = K_MOVI;
                urd_next   = rd_next;
            end
            S_ADD: begin
                valid_next = 1'b1;
                kind_next  = K_ADD;
                urd_next   = rd_next;
                urs1_next  = rd_next;
                urs2_next  = SCRATCH_REG;
            end
            S_SHIFT: begin
                valid_next = 1'b1;
                kind_next  = K_LSLI;
                urd_next   = SCRATCH_REG;
                urs1_next  = SCRATCH_REG;
                uimm_next  = {{(IMM_W-1){1'b0}}, 1'b1};
            end
            default: begin
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            rd_reg    <= '0;
            rs_reg    <= '0;
            imm_reg   <= '0;
            bit_reg   <= '0;
            index_reg <= '0;
            valid_reg <= 1'b0;
            kind_reg  <= K_MOVR;
            urd_reg   <= '0;
            urs1_reg  <= '0;
            urs2_reg  <= '0;
            uimm_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            rd_reg    <= rd_next;
            rs_reg    <= rs_next;
            imm_reg   <= imm_next;
            bit_reg   <= bit_next;
            index_reg <= index_next;
            valid_reg <= valid_next;
            kind_reg  <= kind_next;
            urd_reg   <= urd_next;
            urs1_reg  <= urs1_next;
            urs2_reg  <= urs2_next;
            uimm_reg  <= uimm_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    assign uop_valid = valid_reg;
    assign uop_kind  = kind_reg;
    assign uop_rd    = urd_reg;
    assign uop_rs1   = urs1_reg;
    assign uop_rs2   = urs2_reg;
    assign uop_imm   = uimm_reg;
    assign uop_index = index_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_mul_imm_sequencer.sv
// Scoreboard bench for mul_imm_sequencer: stimulus queues expected micro-ops and done records,
// a negedge monitor checks every fired micro-op and executes it on a small register-file model.
module tb_mul_imm_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  mul_rd;
    logic [3:0]  mul_rs;
    logic [15:0] mul_imm;
    logic        flush;
    logic        uop_valid;
    logic        uop_ready;
    logic [1:0]  uop_kind;
    logic [3:0]  uop_rd;
    logic [3:0]  uop_rs1;
    logic [3:0]  uop_rs2;
    logic [15:0] uop_imm;
    logic [5:0]  uop_index;
    logic        busy;
    logic        done;
    logic        err;

    mul_imm_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mul_rd    (mul_rd),
        .mul_rs    (mul_rs),
        .mul_imm   (mul_imm),
        .flush     (flush),
        .uop_valid (uop_valid),
        .uop_ready (uop_ready),
        .uop_kind  (uop_kind),
        .uop_rd    (uop_rd),
        .uop_rs1   (uop_rs1),
        .uop_rs2   (uop_rs2),
        .uop_imm   (uop_imm),
        .uop_index (uop_index),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] imm;
        logic [5:0]  idx;
    } uop_t;

    typedef struct packed {
        logic [5:0]  idx;
        logic [3:0]  rd;
        logic [31:0] prod;
    } done_t;

    uop_t        exp_q[$];
    done_t       done_q[$];
    logic [5:0]  exp_pos;
    logic [31:0] rf[16];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_uop(input logic [1:0] k, input logic [3:0] d, input logic [3:0] s1,
                            input logic [3:0] s2, input logic [15:0] im);
        exp_q.push_back(uop_t'{k, d, s1, s2, im, exp_pos});
        exp_pos = exp_pos + 6'd1;
    endtask

    task automatic p_movr(input logic [3:0] s);  push_uop(2'd0, 4'd15, s, 4'd0, 16'd0); endtask
    task automatic p_movi(input logic [3:0] d);  push_uop(2'd1, d, 4'd0, 4'd0, 16'd0); endtask
    task automatic p_add(input logic [3:0] d);   push_uop(2'd2, d, d, 4'd15, 16'd0); endtask
    task automatic p_lsli();                     push_uop(2'd3, 4'd15, 4'd15, 4'd0, 16'd1); endtask

    // Bit-serial expansion used for the long directed vectors.
    task automatic gen_expected(input logic [3:0] d, input logic [3:0] s, input logic [15:0] im);
        exp_pos = 6'd0;
        if (im != 16'd0) p_movr(s);
        p_movi(d);
        for (int b = 0; b < 16; b++) begin
            if ((im >> b) == 16'd0) break;
            if (b > 0) p_lsli();
            if (im[b]) p_add(d);
        end
    endtask

    task automatic do_start(input logic [3:0] d, input logic [3:0] s, input logic [15:0] im);
        mul_rd  = d;
        mul_rs  = s;
        mul_imm = im;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int k = 0; k < max_cycles && busy; k++) tick();
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles", max_cycles);
        end
        tick();
    endtask

    // Monitor: compares fired micro-ops, checks stall stability and done records.
    logic  prev_stall = 1'b0;
    uop_t  prev_uop;
    always @(negedge clk) begin
        uop_t  got;
        uop_t  exp;
        done_t dexp;
        got = uop_t'{uop_kind, uop_rd, uop_rs1, uop_rs2, uop_imm, uop_index};
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(uop_valid), 64'd1);
                chk("stall_fields", 64'(got), 64'(prev_uop));
            end
            if (uop_valid && uop_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_uop", 64'(got), 64'hFFFF_FFFF_FFFF);
                end else begin
                    exp = exp_q.pop_front();
                    chk("uop", 64'(got), 64'(exp));
                    $display("uop #%0d kind=%0d rd=%0d rs1=%0d rs2=%0d imm=%0d",
                             uop_index, uop_kind, uop_rd, uop_rs1, uop_rs2, uop_imm);
                end
                case (uop_kind)
                    2'd0: rf[uop_rd] = rf[uop_rs1];
                    2'd1: rf[uop_rd] = {16'd0, uop_imm};
                    2'd2: rf[uop_rd] = rf[uop_rs1] + rf[uop_rs2];
                    default: rf[uop_rd] = rf[uop_rs1] << uop_imm;
                endcase
            end
            if (done) begin
                chk("done_valid_low", 64'(uop_valid), 64'd0);
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    dexp = done_q.pop_front();
                    chk("done_index", 64'(uop_index), 64'(dexp.idx));
                    chk("product", 64'(rf[dexp.rd]), 64'(dexp.prod));
                    chk("uops_drained", 64'(exp_q.size()), 64'd0);
                    $display("done index=%0d r%0d=0x%0h", uop_index, dexp.rd, rf[dexp.rd]);
                end
            end
            prev_stall = uop_valid && !uop_ready && !flush;
            prev_uop   = got;
        end
    end

    initial begin
        int cnt;
        for (int r = 0; r < 16; r++) rf[r] = 32'd0;
        rst = 1'b1; start = 1'b0; flush = 1'b0; uop_ready = 1'b1;
        mul_rd = 4'd0; mul_rs = 4'd0; mul_imm = 16'd0; exp_pos = 6'd0;
        tick(); tick();
        chk("rst_valid", 64'(uop_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_index", 64'(uop_index), 64'd0);
        chk("rst_fields", 64'({uop_kind, uop_rd, uop_rs1, uop_rs2, uop_imm}), 64'd0);
        rst = 1'b0;
        tick();

        // 3 * 5 into r4
        rf[3] = 32'd3;
        exp_pos = 6'd0;
        p_movr(4'd3); p_movi(4'd4); p_add(4'd4); p_lsli(); p_lsli(); p_add(4'd4);
        done_q.push_back(done_t'{6'd6, 4'd4, 32'd15});
        do_start(4'd4, 4'd3, 16'd5);
        chk("latency_valid", 64'(uop_valid), 64'd1);
        chk("latency_busy", 64'(busy), 64'd1);
        wait_idle(50);

        // imm = 0: single MOVI, busy for two cycles
        gen_expected(4'd4, 4'd3, 16'd0);
        done_q.push_back(done_t'{6'd1, 4'd4, 32'd0});
        do_start(4'd4, 4'd3, 16'd0);
        cnt = 0;
        for (int k = 0; k < 10 && busy; k++) begin
            cnt++;
            tick();
        end
        chk("imm0_busy_cycles", 64'(cnt), 64'd2);
        tick();

        // imm = 0xFFFF: maximum-length expansion
        rf[3] = 32'd3;
        gen_expected(4'd4, 4'd3, 16'hFFFF);
        chk("ffff_uop_count", 64'(exp_q.size()), 64'd33);
        done_q.push_back(done_t'{6'd33, 4'd4, 32'h0002_FFFD});
        do_start(4'd4, 4'd3, 16'hFFFF);
        wait_idle(100);

        // imm = 0x8000 with ready toggling every cycle
        rf[3] = 32'd3;
        gen_expected(4'd4, 4'd3, 16'h8000);
        chk("8000_uop_count", 64'(exp_q.size()), 64'd18);
        done_q.push_back(done_t'{6'd18, 4'd4, 32'h0001_8000});
        uop_ready = 1'b0;
        do_start(4'd4, 4'd3, 16'h8000);
        for (int k = 0; k < 100 && busy; k++) begin
            uop_ready = ~uop_ready;
            tick();
        end
        chk("8000_finished", 64'(busy), 64'd0);
        uop_ready = 1'b1;
        tick();

        // rejected starts using the scratch register
        do_start(4'd15, 4'd3, 16'd5);
        chk("err_rd_pulse", 64'(err), 64'd1);
        chk("err_rd_busy", 64'(busy), 64'd0);
        chk("err_rd_valid", 64'(uop_valid), 64'd0);
        tick();
        chk("err_one_cycle", 64'(err), 64'd0);
        do_start(4'd4, 4'd15, 16'd1);
        chk("err_rs_pulse", 64'(err), 64'd1);
        tick();

        // flush wins over a same-cycle start in IDLE
        flush = 1'b1;
        do_start(4'd4, 4'd3, 16'd5);
        flush = 1'b0;
        chk("flush_start_busy", 64'(busy), 64'd0);
        chk("flush_start_err", 64'(err), 64'd0);
        tick();

        // rd == rs: copy precedes clear, r2 = 3 * 7
        rf[2] = 32'd7;
        exp_pos = 6'd0;
        p_movr(4'd2); p_movi(4'd2); p_add(4'd2); p_lsli(); p_add(4'd2);
        done_q.push_back(done_t'{6'd5, 4'd2, 32'd21});
        do_start(4'd2, 4'd2, 16'd3);
        wait_idle(50);

        // flush on the third micro-op of imm = 7
        exp_pos = 6'd0;
        p_movr(4'd3); p_movi(4'd4);
        do_start(4'd4, 4'd3, 16'd7);
        tick(); tick();
        chk("flush_target_add", 64'(uop_kind), 64'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", 64'(uop_valid), 64'd0);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_index", 64'(uop_index), 64'd0);
        chk("flush_done", 64'(done), 64'd0);
        tick();
        chk("flush_no_late_done", 64'(done), 64'd0);

        // fresh start after flush: 3 * 6 into r5
        rf[3] = 32'd3;
        exp_pos = 6'd0;
        p_movr(4'd3); p_movi(4'd5); p_lsli(); p_add(4'd5); p_lsli(); p_add(4'd5);
        done_q.push_back(done_t'{6'd6, 4'd5, 32'd18});
        do_start(4'd5, 4'd3, 16'd6);
        wait_idle(50);

        // asynchronous reset mid-stream
        gen_expected(4'd4, 4'd3, 16'hFFFF);
        do_start(4'd4, 4'd3, 16'hFFFF);
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(uop_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_index", 64'(uop_index), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        tick();
        exp_q.delete();
        done_q.delete();
        rst = 1'b0;
        tick();
        chk("arst_stays_idle", 64'(busy), 64'd0);

        // fresh start after reset
        rf[3] = 32'd3;
        exp_pos = 6'd0;
        p_movr(4'd3); p_movi(4'd4); p_add(4'd4); p_lsli(); p_lsli(); p_add(4'd4);
        done_q.push_back(done_t'{6'd6, 4'd4, 32'd15});
        do_start(4'd4, 4'd3, 16'd5);
        wait_idle(50);

        tick(); tick();
        chk("final_uops_left", 64'(exp_q.size()), 64'd0);
        chk("final_dones_left", 64'(done_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
